up_down_counter_nch: RTL and testbench

//  Parametrised multi-channel up/down counter, successor to the single 8-bit counter.
//  NCH independent counters of WIDTH bits, each with:
//   - per-channel enable, direction, step size, parallel load and synchronous clear
//   - wrap or saturate mode on overflow/underflow
//   - terminal-count pulse and sticky overflow flag

---
 rtl/up_down_counter_nch.sv | 83 ++++++++
 tb/tb_up_down_counter_nch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_nch.sv
// Bank of NCH independent up/down counters with per-channel step, load and clear.
// Each channel can wrap or saturate on overflow, and reports a terminal-count pulse and a sticky overflow flag.
module up_down_counter_nch #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NCH-1:0]          clr_i,
  input  logic [NCH-1:0]          load_i,
  input  logic [NCH*WIDTH-1:0]    load_val_i,
  input  logic [NCH-1:0]          en_i,
  input  logic [NCH-1:0]          up_down_i,
  input  logic [NCH*STEP_W-1:0]   step_i,
  output logic [NCH*WIDTH-1:0]    cntr_o,
  output logic [NCH-1:0]          tc_o,
  output logic [NCH-1:0]          ovf_o
);

  localparam int unsigned SUM_W = WIDTH + 1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [SUM_W-1:0] step_ext;
    logic [SUM_W-1:0] sum;

    // Next-state selection: clear beats load, load beats count, otherwise hold.
    always_comb begin
      step_ext = SUM_W'(step_i[c*STEP_W +: STEP_W]);
      if (up_down_i[c]) begin
        sum = SUM_W'(cnt_q) + step_ext;
      end else begin
        sum = SUM_W'(cnt_q) - step_ext;
      end

      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;

      if (clr_i[c]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (load_i[c]) begin
        cnt_d = load_val_i[c*WIDTH +: WIDTH];
      end else if (en_i[c]) begin
        cnt_d = sum[WIDTH-1:0];
        // The extra top bit is the carry when counting up, or the borrow when counting down.
        if (sum[WIDTH]) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE != 0) begin
            cnt_d = up_down_i[c] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          end
        end
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tc_q  <= tc_d;
        ovf_q <= ovf_d;
      end
    end

    assign cntr_o[c*WIDTH +: WIDTH] = cnt_q;
    assign tc_o[c]                  = tc_q;
    assign ovf_o[c]                 = ovf_q;
  end

endmodule

// File: tb/tb_up_down_counter_nch.sv
// Directed bench for up_down_counter_nch: one wrap-mode and one saturate-mode instance
// share the same stimulus.
module tb_up_down_counter_nch;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NCH    = 4;
  localparam int unsigned STEP_W = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NCH-1:0]        clr;
  logic [NCH-1:0]        load;
  logic [NCH*WIDTH-1:0]  load_val;
  logic [NCH-1:0]        en;
  logic [NCH-1:0]        up_down;
  logic [NCH*STEP_W-1:0] step;
  logic [NCH*WIDTH-1:0]  cntr;
  logic [NCH-1:0]        tc;
  logic [NCH-1:0]        ovf;
  logic [NCH*WIDTH-1:0]  cntr_s;
  logic [NCH-1:0]        tc_s;
  logic [NCH-1:0]        ovf_s;

  int checks = 0;
  int errors = 0;

  up_down_counter_nch #(.WIDTH(WIDTH), .NCH(NCH), .STEP_W(STEP_W), .SATURATE(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_down_i(up_down), .step_i(step),
    .cntr_o(cntr), .tc_o(tc), .ovf_o(ovf)
  );

  up_down_counter_nch #(.WIDTH(WIDTH), .NCH(NCH), .STEP_W(STEP_W), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
    .en_i(en), .up_down_i(up_down), .step_i(step),
    .cntr_o(cntr_s), .tc_o(tc_s), .ovf_o(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic e, input logic up, input int st);
    en[c]                   = e;
    up_down[c]              = up;
    step[c*STEP_W +: STEP_W] = STEP_W'(st);
  endtask

  task automatic load_ch(input int c, input int val);
    load[c]                    = 1'b1;
    load_val[c*WIDTH +: WIDTH] = WIDTH'(val);
    tick();
    load[c] = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    #12;
    checks++;
    if (cntr !== '0 || tc !== '0 || ovf !== '0) begin
      errors++; $display("FAIL reset_wrap: cntr=%h tc=%b ovf=%b, want 0", cntr, tc, ovf);
    end
    checks++;
    if (cntr_s !== '0 || tc_s !== '0 || ovf_s !== '0) begin
      errors++; $display("FAIL reset_sat: cntr=%h tc=%b ovf=%b, want 0", cntr_s, tc_s, ovf_s);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ch(0, 1'b1, 1'b1, 1);
    repeat (5) tick();
    v = cntr[7:0];
    checks++;
    if (v !== 8'd5) begin
      errors++; $display("FAIL count5: ch0=%h want 05", v);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (cntr !== '0 || tc !== '0 || ovf !== '0) begin
      errors++; $display("FAIL reset_mid: cntr=%h tc=%b ovf=%b, want 0", cntr, tc, ovf);
    end
    #1 rst_n = 1'b1;
    repeat (3) tick();
    v = cntr[7:0];
    checks++;
    if (v !== 8'd3) begin
      errors++; $display("FAIL count_after_reset: ch0=%h want 03", v);
    end
    set_ch(0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_wrap();
    load_ch(1, 'hFE);
    checks++;
    if (cntr[15:8] !== 8'hFE) begin
      errors++; $display("FAIL wrap_load: ch1=%h want fe", cntr[15:8]);
    end
    set_ch(1, 1'b1, 1'b1, 3);
    tick();
    checks++;
    if (cntr[15:8] !== 8'h01 || tc[1] !== 1'b1 || ovf[1] !== 1'b1) begin
      errors++; $display("FAIL wrap_up: ch1=%h tc=%b ovf=%b want 01 1 1", cntr[15:8], tc[1], ovf[1]);
    end
    set_ch(1, 1'b0, 1'b1, 3);
    tick();
    checks++;
    if (cntr[15:8] !== 8'h01 || tc[1] !== 1'b0 || ovf[1] !== 1'b1) begin
      errors++; $display("FAIL wrap_hold: ch1=%h tc=%b ovf=%b want 01 0 1", cntr[15:8], tc[1], ovf[1]);
    end
    set_ch(1, 1'b1, 1'b0, 2);
    tick();
    checks++;
    if (cntr[15:8] !== 8'hFF || tc[1] !== 1'b1 || ovf[1] !== 1'b1) begin
      errors++; $display("FAIL wrap_down: ch1=%h tc=%b ovf=%b want ff 1 1", cntr[15:8], tc[1], ovf[1]);
    end
    set_ch(1, 1'b0, 1'b0, 0);
    tick();
    checks++;
    if (tc[1] !== 1'b0 || cntr[15:8] !== 8'hFF) begin
      errors++; $display("FAIL wrap_tc_pulse: ch1=%h tc=%b want ff 0", cntr[15:8], tc[1]);
    end
  endtask

  task automatic test_saturate();
    load_ch(2, 'h02);
    set_ch(2, 1'b1, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cntr_s[23:16] !== 8'h00 || tc_s[2] !== 1'b1 || ovf_s[2] !== 1'b1) begin
        errors++; $display("FAIL sat_down[%0d]: ch2=%h tc=%b ovf=%b want 00 1 1", i, cntr_s[23:16], tc_s[2], ovf_s[2]);
      end
    end
    set_ch(2, 1'b1, 1'b1, 1);
    tick();
    checks++;
    if (cntr_s[23:16] !== 8'h01 || tc_s[2] !== 1'b0 || ovf_s[2] !== 1'b1) begin
      errors++; $display("FAIL sat_recover: ch2=%h tc=%b ovf=%b want 01 0 1", cntr_s[23:16], tc_s[2], ovf_s[2]);
    end
    set_ch(2, 1'b0, 1'b1, 0);
  endtask

  task automatic test_priority();
    load_ch(3, 'hFF);
    set_ch(3, 1'b1, 1'b1, 1);
    tick();
    checks++;
    if (cntr[31:24] !== 8'h00 || ovf[3] !== 1'b1) begin
      errors++; $display("FAIL prio_setup: ch3=%h ovf=%b want 00 1", cntr[31:24], ovf[3]);
    end
    clr[3] = 1'b1; load[3] = 1'b1; load_val[31:24] = 8'h77; set_ch(3, 1'b1, 1'b1, 4);
    tick();
    clr[3] = 1'b0;
    checks++;
    if (cntr[31:24] !== 8'h00 || ovf[3] !== 1'b0 || tc[3] !== 1'b0) begin
      errors++; $display("FAIL prio_clr: ch3=%h ovf=%b tc=%b want 00 0 0", cntr[31:24], ovf[3], tc[3]);
    end
    load_val[31:24] = 8'h40;
    tick();
    load[3] = 1'b0;
    checks++;
    if (cntr[31:24] !== 8'h40 || tc[3] !== 1'b0) begin
      errors++; $display("FAIL prio_load: ch3=%h tc=%b want 40 0", cntr[31:24], tc[3]);
    end
    set_ch(3, 1'b1, 1'b1, 0);
    tick();
    checks++;
    if (cntr[31:24] !== 8'h40 || tc[3] !== 1'b0) begin
      errors++; $display("FAIL step_zero: ch3=%h tc=%b want 40 0", cntr[31:24], tc[3]);
    end
    set_ch(3, 1'b0, 1'b1, 0);
  endtask

  task automatic test_boundary();
    load_ch(0, 'hFC);
    set_ch(0, 1'b1, 1'b1, 3);
    tick();
    checks++;
    if (cntr[7:0] !== 8'hFF || tc[0] !== 1'b0 || cntr_s[7:0] !== 8'hFF || tc_s[0] !== 1'b0) begin
      errors++; $display("FAIL exact_max: ch0=%h/%h tc=%b/%b want ff 0", cntr[7:0], cntr_s[7:0], tc[0], tc_s[0]);
    end
    set_ch(0, 1'b1, 1'b1, 1);
    tick();
    checks++;
    if (cntr[7:0] !== 8'h00 || tc[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_past_max: ch0=%h tc=%b want 00 1", cntr[7:0], tc[0]);
    end
    checks++;
    if (cntr_s[7:0] !== 8'hFF || tc_s[0] !== 1'b1) begin
      errors++; $display("FAIL sat_past_max: ch0=%h tc=%b want ff 1", cntr_s[7:0], tc_s[0]);
    end
    set_ch(0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_independence();
    int mc[NCH], ms[NCH];
    bit mt[NCH], mts[NCH], mo[NCH], mos[NCH];
    logic [NCH*WIDTH-1:0] exp_c, exp_cs;
    logic [NCH-1:0] exp_t, exp_ts, exp_o, exp_os;
    int v, lv, st;
    bit e, up, ld;
    clr = '1;
    tick();
    clr = '0;
    for (int c = 0; c < NCH; c++) begin
      mc[c] = 0; ms[c] = 0; mo[c] = 0; mos[c] = 0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        e  = ((cyc + c) % 5) != 0;
        up = ((cyc / 7 + c) % 2) == 0;
        st = (cyc * 3 + c * 5) % 16;
        ld = (cyc % 37) == c * 3;
        lv = (cyc * 11 + c * 29) % 256;
        set_ch(c, e, up, st);
        load[c] = ld;
        load_val[c*WIDTH +: WIDTH] = WIDTH'(lv);
        mt[c] = 0; mts[c] = 0;
        if (ld) begin
          mc[c] = lv; ms[c] = lv;
        end else if (e) begin
          v = up ? mc[c] + st : mc[c] - st;
          if (v > 255 || v < 0) begin mt[c] = 1; mo[c] = 1; end
          mc[c] = v & 255;
          v = up ? ms[c] + st : ms[c] - st;
          if (v > 255 || v < 0) begin
            mts[c] = 1; mos[c] = 1;
            v = up ? 255 : 0;
          end
          ms[c] = v;
        end
        exp_c[c*WIDTH +: WIDTH]  = WIDTH'(mc[c]);
        exp_cs[c*WIDTH +: WIDTH] = WIDTH'(ms[c]);
        exp_t[c] = mt[c]; exp_ts[c] = mts[c]; exp_o[c] = mo[c]; exp_os[c] = mos[c];
      end
      tick();
      checks++;
      if (cntr !== exp_c || tc !== exp_t || ovf !== exp_o) begin
        errors++;
        $display("FAIL indep_wrap cyc %0d: cntr=%h tc=%b ovf=%b want %h %b %b", cyc, cntr, tc, ovf, exp_c, exp_t, exp_o);
      end
      checks++;
      if (cntr_s !== exp_cs || tc_s !== exp_ts || ovf_s !== exp_os) begin
        errors++;
        $display("FAIL indep_sat cyc %0d: cntr=%h tc=%b ovf=%b want %h %b %b", cyc, cntr_s, tc_s, ovf_s, exp_cs, exp_ts, exp_os);
      end
    end
    load = '0;
    en   = '0;
  endtask

  initial begin
    rst_n = 1'b0; clr = '0; load = '0; load_val = '0;
    en = '0; up_down = '0; step = '0;
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_boundary();
    test_independence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
